// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package pc_fetch_ctrl_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned IMM_W = 26;

   localparam logic [XLEN-1:0] RESET_PC_DEF   = 32'h0000_3000;
   localparam logic [XLEN-1:0] EXC_VECTOR_DEF = 32'h0000_4180;

   // Next-PC select encodings shared with the EX-stage control
   typedef enum logic [1:0] {
      NPC_PLUS4  = 2'd0,
      NPC_BRANCH = 2'd1,
      NPC_JUMP   = 2'd2,
      NPC_JR     = 2'd3
   } npc_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   // Fetched instruction with its address, as handed to IF/ID
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_pkt_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational redirect target computation.
// Ports: op_i/pc_i/imm_i/rs_i describe the redirecting instruction;
//        tgt_c_o is the computed target, misalign_c_o flags tgt[1:0] != 0.
module pc_target_calc
   import pc_fetch_ctrl_pkg::*;
(
   input  npc_op_e          op_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [IMM_W-1:0] imm_i,
   input  logic [XLEN-1:0]  rs_i,
   output logic [XLEN-1:0]  tgt_c_o,
   output logic             misalign_c_o
);

   logic [XLEN-1:0] p4;
   logic [XLEN-1:0] br_off;

   assign p4     = pc_i + XLEN'(4);
   assign br_off = {{14{imm_i[15]}}, imm_i[15:0], 2'b00};

   always_comb begin
      tgt_c_o = p4;
      case (op_i)
         NPC_BRANCH: tgt_c_o = p4 + br_off;
         NPC_JUMP:   tgt_c_o = {p4[31:28], imm_i, 2'b00};
         NPC_JR:     tgt_c_o = rs_i;
         default:    tgt_c_o = p4;
      endcase
   end

   assign misalign_c_o = |tgt_c_o[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC owner and instruction-fetch sequencer.
// Ports: clk/rst (async active-low); stall_i, redir_*_i, exc_i from the
//        pipeline; imem_req_o/imem_addr_o/imem_ack_i/imem_rdata_i memory
//        handshake; if_valid_o/if_pc_o/if_instr_o to IF/ID; flush_o and
//        misalign_o one-cycle pulses on a control transfer.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
   parameter logic [XLEN-1:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             redir_valid_i,
   input  logic [1:0]       redir_op_i,
   input  logic [XLEN-1:0]  redir_pc_i,
   input  logic [IMM_W-1:0] redir_imm_i,
   input  logic [XLEN-1:0]  redir_rs_i,
   input  logic             exc_i,
   output logic             imem_req_o,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic             imem_ack_i,
   input  logic [XLEN-1:0]  imem_rdata_i,
   output logic             if_valid_o,
   output logic [XLEN-1:0]  if_pc_o,
   output logic [XLEN-1:0]  if_instr_o,
   output logic             flush_o,
   output logic             misalign_o
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic            if_valid_q, if_valid_d;
   fetch_pkt_t      if_pkt_q, if_pkt_d;
   logic            skid_valid_q, skid_valid_d;
   fetch_pkt_t      skid_pkt_q, skid_pkt_d;
   logic            flush_q, flush_d;
   logic            misalign_q, misalign_d;

   logic [XLEN-1:0] calc_tgt_c;
   logic            calc_mis_c;
   logic            kill_c;
   logic            ack_c;
   logic [XLEN-1:0] kill_tgt_c;
   fetch_pkt_t      ack_pkt_c;

   pc_target_calc u_target (
      .op_i         (npc_op_e'(redir_op_i)),
      .pc_i         (redir_pc_i),
      .imm_i        (redir_imm_i),
      .rs_i         (redir_rs_i),
      .tgt_c_o      (calc_tgt_c),
      .misalign_c_o (calc_mis_c)
   );

   assign kill_c    = exc_i | redir_valid_i;
   assign ack_c     = req_q & imem_ack_i;
   assign ack_pkt_c = '{pc: addr_q, instr: imem_rdata_i};
   // Exceptions and misaligned redirects both land on the vector
   assign kill_tgt_c = (exc_i || calc_mis_c) ? EXC_VECTOR : calc_tgt_c;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         req_q        <= 1'b0;
         addr_q       <= RESET_PC;
         if_valid_q   <= 1'b0;
         if_pkt_q     <= '0;
         skid_valid_q <= 1'b0;
         skid_pkt_q   <= '0;
         flush_q      <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         if_valid_q   <= if_valid_d;
         if_pkt_q     <= if_pkt_d;
         skid_valid_q <= skid_valid_d;
         skid_pkt_q   <= skid_pkt_d;
         flush_q      <= flush_d;
         misalign_q   <= misalign_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_d        = req_q;
      addr_d       = addr_q;
      if_valid_d   = if_valid_q;
      if_pkt_d     = if_pkt_q;
      skid_valid_d = skid_valid_q;
      skid_pkt_d   = skid_pkt_q;
      flush_d      = 1'b0;
      misalign_d   = 1'b0;

      if (kill_c) begin
         flush_d      = 1'b1;
         misalign_d   = !exc_i && calc_mis_c;
         if_valid_d   = 1'b0;
         skid_valid_d = 1'b0;
         pc_d         = kill_tgt_c;
         // An unanswered request must complete before the new target goes out
         if (req_q && !imem_ack_i) begin
            state_d = DRAIN;
         end else begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = kill_tgt_c;
         end
      end else begin
         case (state_q)
            IDLE: begin
               state_d = REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
            REQ: begin
               if (ack_c) begin
                  pc_d = pc_q + XLEN'(4);
                  if (stall_i) begin
                     // IF/ID is frozen: park the word and stop fetching
                     skid_valid_d = 1'b1;
                     skid_pkt_d   = ack_pkt_c;
                     req_d        = 1'b0;
                     state_d      = HOLD;
                  end else begin
                     if_valid_d = 1'b1;
                     if_pkt_d   = ack_pkt_c;
                     addr_d     = pc_q + XLEN'(4);
                  end
               end else if (!stall_i) begin
                  if_valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  if_valid_d   = skid_valid_q;
                  if_pkt_d     = skid_pkt_q;
                  skid_valid_d = 1'b0;
                  state_d      = REQ;
                  req_d        = 1'b1;
                  addr_d       = pc_q;
               end
            end
            DRAIN: begin
               if_valid_d = 1'b0;
               // Drained word is dropped; pc_q already holds the saved target
               if (ack_c) begin
                  state_d = REQ;
                  addr_d  = pc_q;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign imem_req_o  = req_q;
   assign imem_addr_o = addr_q;
   assign if_valid_o  = if_valid_q;
   assign if_pc_o     = if_pkt_q.pc;
   assign if_instr_o  = if_pkt_q.instr;
   assign flush_o     = flush_q;
   assign misalign_o  = misalign_q;

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Owns the architectural PC register for the pipelined CPU.
- Sequences instruction fetch over a req/ack instruction-memory handshake.
- Applies redirects resolved in EX (branch/jump/jr, using the NPC_* op encoding), exceptions and hazard stalls.
- Delivers fetched instructions to the IF/ID register, with a valid and flush indication.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC loaded on exception or on a misaligned redirect target.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall_i  input  1  hazard unit: hold IF output and do not advance the PC.
- redir_valid_i  input  1  EX stage resolved a control transfer this cycle.
- redir_op_i  input  2  NPC_PLUS4 / NPC_BRANCH / NPC_JUMP / NPC_JR.
- redir_pc_i  input  32  PC of the redirecting instruction.
- redir_imm_i  input  26  branch offset [15:0] or jump index [25:0].
- redir_rs_i  input  32  rs value for NPC_JR.
- exc_i  input  1  exception request; highest priority.
- imem_req_o  output  1  fetch request; held until ack.
- imem_addr_o  output  32  fetch address; stable while req is high.
- imem_ack_i  input  1  memory returns data this cycle.
- imem_rdata_i  input  32  instruction word, valid with ack.
- if_valid_o  output  1  if_pc_o/if_instr_o hold a live instruction.
- if_pc_o  output  32  PC of the delivered instruction.
- if_instr_o  output  32  delivered instruction.
- flush_o  output  1  one-cycle pulse: kill the IF/ID (and ID/EX) contents.
- misalign_o  output  1  one-cycle pulse: redirect target had [1:0] != 0.

Behaviour:
- Reset (rst low, async): pc = RESET_PC; state = IDLE; all outputs 0 except imem_addr_o = RESET_PC.
- Target arithmetic: p4 = redir_pc_i + 4. Per op:
  - BRANCH: p4 + sext(imm[15:0]) << 2.
  - JUMP: {p4[31:28], imm, 2'b00}.
  - JR: redir_rs_i.
  - PLUS4 and undefined codes: p4.
  - All sums mod 2^32; wrap-around is allowed.
- States:
  - IDLE: first cycle after reset release. Go to REQ.
  - REQ: imem_req_o = 1, imem_addr_o = pc. On ack go to REQ with pc+4, or HOLD if a stall is asserted. No ack: stay.
  - HOLD: output registers frozen; no request. Leave when stall_i deasserts.
  - DRAIN: a fetch was in flight when a redirect or exception hit. imem_req_o stays high with the old address until ack; the data is discarded. Next state is REQ at the saved target.
- Ack handling (no kill pending): if_valid_o = 1, if_pc_o = addr, if_instr_o = rdata, all registered; visible the cycle after ack.
- Stall: if_* outputs hold while stall_i = 1. An ack arriving during a stall is buffered in a one-entry skid register and presented when the stall drops. No fetch is issued while the skid is full.
- Priority per cycle: exc_i > redir_valid_i > stall_i > sequential.
- Exception or redirect:
  - Saves the target (EXC_VECTOR for an exception) and pulses flush_o for 1 cycle.
  - Clears if_valid_o and the skid register next cycle.
  - Goes to DRAIN if a request is outstanding without ack, otherwise to REQ.
  - A redirect overrides a stall.
- Misaligned target: any target with [1:0] != 0 is replaced by EXC_VECTOR and pulses misalign_o with flush_o.
- A second redirect during DRAIN overwrites the saved target; the last one wins. flush_o pulses again.
- Redirect and ack in the same cycle: the acked data is discarded and the new target is requested next cycle (no DRAIN).
- Latency: sequential throughput is 1 instruction per cycle with a zero-wait memory. Redirect-to-request is 1 cycle plus any drain.

Decomposition:
- Shared package/include: NPC_* op encodings (same values as the existing next-PC select), state encodings IDLE/REQ/HOLD/DRAIN, RESET_PC/EXC_VECTOR defaults.
- One sub-module, pc_target_calc: combinational target plus misalignment flag.

Test Plan:
- Reset release, zero-wait ack: requests at 0x3000, 0x3004, 0x3008; if_pc_o follows 1 cycle behind; if_valid_o = 1 from the 2nd cycle.
- BRANCH at redir_pc 0x3010, imm 0xFFFC: target 0x3004, flush_o pulses once, next imem_addr_o = 0x3004.
- JR rs = 0x3002: misalign_o and flush_o pulse, next fetch at 0x4180.
- Redirect JUMP imm 0x0000100 while ack withheld 3 cycles: DRAIN holds addr; data discarded (if_valid_o = 0); next req at 0x0000_0400.
- stall_i high 4 cycles while ack arrives: skid captures, if_* frozen, released data appears in order with no duplicate or loss.
- Async reset asserted mid-DRAIN: outputs clear immediately; the restart fetches 0x3000.
